// File: rtl/elementwise_mac_unit.sv
// Winograd F(4x4,3x3) Hadamard stage: M = U.*V or M += U.*V.
// Ports: clk, rst_n (async low), start, acc_en, U, V -> M, done, busy.
module elementwise_mac_unit #(
    parameter int IN_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       acc_en,
    input  logic signed [IN_WIDTH-1:0] U [0:5][0:5],
    input  logic signed [IN_WIDTH-1:0] V [0:5][0:5],
    output logic signed [63:0]         M [0:5][0:5],
    output logic                       done,
    output logic                       busy
);

    localparam int PW = 2 * IN_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [2:0]         r_row;
    logic               r_acc;
    logic               r_done;
    logic               r_busy;
    logic signed [63:0] r_m [0:5][0:5];

    // One row of six shared multipliers, selected by the current row.
    logic signed [63:0] w_p [0:5];

    always_comb begin
        for (int c = 0; c < 6; c++) begin
            w_p[c] = 64'(PW'(U[r_row][c]) * PW'(V[r_row][c]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= 3'd0;
            r_acc   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 6; c++) begin
                    r_m[r][c] <= 64'sd0;
                end
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc   <= acc_en;
                        r_row   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_MUL: begin
                    // Only the current row is written; others hold.
                    for (int c = 0; c < 6; c++) begin
                        if (r_acc) begin
                            r_m[r_row][c] <= r_m[r_row][c] + w_p[c];
                        end else begin
                            r_m[r_row][c] <= w_p[c];
                        end
                    end
                    if (r_row == 3'd5) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_row <= r_row + 3'd1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign M    = r_m;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_elementwise_mac_unit.sv
// Directed self-checking bench for elementwise_mac_unit.
// Each task drives one scenario and checks hand-derived values.
module tb_elementwise_mac_unit;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               acc_en;
    logic signed [31:0] U [0:5][0:5];
    logic signed [31:0] V [0:5][0:5];
    logic signed [63:0] M [0:5][0:5];
    logic               done;
    logic               busy;

    int checks;
    int errors;

    elementwise_mac_unit #(.IN_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .acc_en (acc_en),
        .U      (U),
        .V      (V),
        .M      (M),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic signed [31:0] u,
                        input logic signed [31:0] v);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                U[r][c] = u;
                V[r][c] = v;
            end
        end
    endtask

    // Drives one complete operation: start seen at edge k, start low
    // from k+1, finishes in S_IDLE after edge k+7.
    task automatic do_op(input logic acc);
        start  = 1'b1;
        acc_en = acc;
        step();
        start  = 1'b0;
        acc_en = 1'b0;
        repeat (7) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== 64'sd0) begin
                    errors++;
                    $display("FAIL reset_m[%0d][%0d] got %0d want 0",
                             r, c, M[r][c]);
                end
            end
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got done=%b busy=%b want 0 0",
                     done, busy);
        end
        rst_n = 1'b1;
        fill(32'sd7, 32'sd7);
        repeat (10) step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || M[5][5] !== 64'sd0) begin
            errors++;
            $display("FAIL idle got done=%b busy=%b m55=%0d want 0 0 0",
                     done, busy, M[5][5]);
        end
    endtask

    task automatic test_overwrite();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                U[r][c] = 32'(r * 6 + c);
                V[r][c] = 32'sd2;
            end
        end
        start  = 1'b1;
        acc_en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ow_k got busy=%b done=%b want 1 0", busy, done);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[i-1][c] !== 64'(2 * ((i - 1) * 6 + c))) begin
                    errors++;
                    $display("FAIL ow_row%0d_c%0d got %0d want %0d",
                             i - 1, c, M[i-1][c], 2 * ((i - 1) * 6 + c));
                end
            end
            if (i < 6) begin
                checks++;
                if (M[i][0] !== 64'sd0) begin
                    errors++;
                    $display("FAIL ow_unwritten_row%0d got %0d want 0",
                             i, M[i][0]);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL ow_busy_k%0d got busy=%b done=%b want 1 0",
                             i, busy, done);
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL ow_done got busy=%b done=%b want 0 1",
                             busy, done);
                end
            end
        end
        repeat (3) step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || M[5][5] !== 64'sd70) begin
            errors++;
            $display("FAIL ow_hold got done=%b busy=%b m55=%0d want 1 0 70",
                     done, busy, M[5][5]);
        end
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ow_clear got done=%b busy=%b want 0 0",
                     done, busy);
        end
        step();
    endtask

    task automatic test_accumulate();
        fill(32'sd3, 32'sd3);
        do_op(1'b0);
        checks++;
        if (M[2][4] !== 64'sd9) begin
            errors++;
            $display("FAIL acc_first got %0d want 9", M[2][4]);
        end
        fill(-32'sd4, 32'sd5);
        do_op(1'b1);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== -64'sd11) begin
                    errors++;
                    $display("FAIL acc_m[%0d][%0d] got %0d want -11",
                             r, c, M[r][c]);
                end
            end
        end
    endtask

    task automatic test_extremes();
        fill(32'sh8000_0000, 32'sh8000_0000);
        do_op(1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== 64'sh4000_0000_0000_0000) begin
                    errors++;
                    $display("FAIL ext_m[%0d][%0d] got %h want 4000000000000000",
                             r, c, M[r][c]);
                end
            end
        end
        do_op(1'b1);
        checks++;
        if (M[3][1] !== 64'sh8000_0000_0000_0000) begin
            errors++;
            $display("FAIL ext_x2 got %h want 8000000000000000", M[3][1]);
        end
        do_op(1'b1);
        do_op(1'b1);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== 64'sd0) begin
                    errors++;
                    $display("FAIL ext_wrap[%0d][%0d] got %h want 0",
                             r, c, M[r][c]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        fill(32'sd3, 32'sd3);
        do_op(1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                U[r][c] = 32'(r * 6 + c);
                V[r][c] = 32'sd2;
            end
        end
        start  = 1'b1;
        acc_en = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        start  = 1'b1;
        acc_en = 1'b1;
        step();
        start  = 1'b0;
        acc_en = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ign_k5 got busy=%b done=%b want 1 0", busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL ign_k6 got busy=%b done=%b want 0 1", busy, done);
        end
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ign_second_op got busy=%b done=%b want 0 0",
                     busy, done);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== 64'(2 * (r * 6 + c))) begin
                    errors++;
                    $display("FAIL ign_m[%0d][%0d] got %0d want %0d",
                             r, c, M[r][c], 2 * (r * 6 + c));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fill(32'sd3, 32'sd3);
        start  = 1'b1;
        acc_en = 1'b1;
        step();
        start  = 1'b0;
        acc_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_flags got busy=%b done=%b want 0 0",
                     busy, done);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== 64'sd0) begin
                    errors++;
                    $display("FAIL mid_m[%0d][%0d] got %0d want 0",
                             r, c, M[r][c]);
                end
            end
        end
        step();
        rst_n = 1'b1;
        step();
        fill(-32'sd6, 32'sd7);
        do_op(1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (M[r][c] !== -64'sd42) begin
                    errors++;
                    $display("FAIL mid_fresh[%0d][%0d] got %0d want -42",
                             r, c, M[r][c]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        acc_en = 1'b0;
        fill(32'sd0, 32'sd0);
        test_reset();
        test_overwrite();
        test_accumulate();
        test_extremes();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
